// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, issues in-order memory requests and
// buffers PC-tagged instructions for decode; redirects flush and drop stale returns.
module fetch_queue #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              req_valid_o,
    output logic [AWIDTH-1:0] req_addr_o,
    input  logic              req_ready_i,
    input  logic              rsp_valid_i,
    input  logic [DWIDTH-1:0] rsp_data_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [AWIDTH-1:0] fetch_pc;
    logic [AWIDTH-1:0] resp_pc;
    logic [CW-1:0]     count;
    logic [CW-1:0]     pending;
    logic [CW-1:0]     discard;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [AWIDTH-1:0] pc_mem   [DEPTH];
    logic [DWIDTH-1:0] insn_mem [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic [CW:0]   used;

    // Credits cover both buffered and in-flight entries, so a push never overflows.
    always_comb begin
        used         = {1'b0, count} + {1'b0, pending};
        req_valid_o  = !rst && !redirect_i && (used < (CW+1)'(DEPTH));
        req_addr_o   = fetch_pc;
        issue        = req_valid_o && req_ready_i;
        insn_valid_o = (count != '0) && !redirect_i;
        pop          = insn_valid_o && insn_ready_i;
        push         = rsp_valid_i && !redirect_i && (discard == '0);
        pc_o         = insn_valid_o ? pc_mem[rd_ptr] : '0;
        insn_o       = insn_valid_o ? insn_mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= BASEADDR;
            resp_pc  <= BASEADDR;
            count    <= '0;
            pending  <= '0;
            discard  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            pending <= pending + CW'(issue) - CW'(rsp_valid_i);
            if (redirect_i) begin
                // Everything still in flight after this cycle is stale.
                fetch_pc <= redirect_pc_i;
                resp_pc  <= redirect_pc_i;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                discard  <= pending - CW'(rsp_valid_i);
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + AWIDTH'(4);
                if (rsp_valid_i && (discard != '0))
                    discard <= discard - CW'(1);
                if (push) begin
                    resp_pc <= resp_pc + AWIDTH'(4);
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= resp_pc;
            insn_mem[wr_ptr] <= rsp_data_i;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue with an in-order memory model and a
// queue-based reference of the fetch buffer, plus directed literal checks.
module tb_fetch_queue;

    localparam logic [31:0] BASE = 32'h01000000;
    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic        redirect = 0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 0;
    logic        rsp_valid = 0;
    logic [31:0] rsp_data = '0;
    logic        insn_valid;
    logic        insn_ready = 0;
    logic [31:0] pc;
    logic [31:0] insn;

    fetch_queue #(
        .DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .req_valid_o(req_valid), .req_addr_o(req_addr), .req_ready_i(req_ready),
        .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data),
        .insn_valid_o(insn_valid), .insn_ready_i(insn_ready),
        .pc_o(pc), .insn_o(insn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } ent_t;

    mreq_t       mq[$];
    ent_t        fq[$];
    logic [31:0] exp_pc = BASE;
    int          cyc = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          nvec = 0;
    int          nerr = 0;

    logic        s_req_valid, s_insn_valid;
    logic [31:0] s_req_addr, s_pc, s_insn;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input bit r, input bit rd, input logic [31:0] rpc,
                        input bit rr, input bit ir);
        bit    e_rv, e_iv, iss, popv, rspv;
        mreq_t h;
        ent_t  e;
        e_rv = 0;
        e_iv = 0;
        @(negedge clk);
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        req_ready   = rr;
        insn_ready  = ir;
        rspv        = !r && mq.size() > 0 && mq[0].due <= cyc;
        rsp_valid   = rspv;
        rsp_data    = rspv ? mq[0].data : '0;
        #1;
        s_req_valid  = req_valid;
        s_req_addr   = req_addr;
        s_insn_valid = insn_valid;
        s_pc         = pc;
        s_insn       = insn;
        if (!r) begin
            e_rv = !rd && (fq.size() + mq.size() < DEPTH);
            e_iv = !rd && fq.size() != 0;
            check("req_valid", {31'b0, req_valid}, {31'b0, e_rv});
            check("req_addr", req_addr, exp_pc);
            check("insn_valid", {31'b0, insn_valid}, {31'b0, e_iv});
            check("pc", pc, e_iv ? fq[0].pc : 32'h0);
            check("insn", insn, e_iv ? fq[0].insn : 32'h0);
        end
        iss  = e_rv && rr;
        popv = e_iv && ir;
        @(posedge clk);
        cyc++;
        if (r) begin
            fq.delete();
            mq.delete();
            exp_pc = BASE;
        end else begin
            if (rspv) h = mq.pop_front();
            if (popv) void'(fq.pop_front());
            if (rspv && !h.stale && !rd) begin
                e.pc   = h.addr;
                e.insn = h.data;
                fq.push_back(e);
            end
            if (rd) begin
                fq.delete();
                foreach (mq[i]) mq[i].stale = 1;
                exp_pc = rpc;
            end else if (iss) begin
                h.addr  = exp_pc;
                h.data  = $urandom;
                h.due   = cyc + $urandom_range(lat_hi, lat_lo) - 1;
                h.stale = 0;
                mq.push_back(h);
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    task automatic wait_first(input string nm, input logic [31:0] want);
        bit found;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(0, 0, 0, 1, 1);
            if (s_insn_valid) found = 1;
        end
        check({nm, "_seen"}, {31'b0, found}, 32'd1);
        if (found) check({nm, "_pc"}, s_pc, want);
    endtask

    initial begin
        // Streaming at latency 1, decode always ready.
        lat_lo = 1; lat_hi = 1;
        do_reset();
        step(0, 0, 0, 1, 1);
        check("first_req_valid", {31'b0, s_req_valid}, 32'd1);
        check("first_req_addr", s_req_addr, 32'h01000000);
        check("first_insn_valid", {31'b0, s_insn_valid}, 32'd0);
        step(0, 0, 0, 1, 1);
        check("second_req_addr", s_req_addr, 32'h01000004);
        step(0, 0, 0, 1, 1);
        check("first_out_valid", {31'b0, s_insn_valid}, 32'd1);
        check("first_out_pc", s_pc, 32'h01000000);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);

        // Decode stall fills exactly DEPTH entries, then drains in order.
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
        check("stall_req_valid", {31'b0, s_req_valid}, 32'd0);
        check("stall_head_pc", s_pc, 32'h01000000);
        check("stall_fifo_size", fq.size(), 32'd4);
        step(0, 0, 0, 1, 1);
        check("drain0_pc", s_pc, 32'h01000000);
        check("drain0_req_valid", {31'b0, s_req_valid}, 32'd0);
        step(0, 0, 0, 1, 1);
        check("drain1_pc", s_pc, 32'h01000004);
        check("resume_req_valid", {31'b0, s_req_valid}, 32'd1);
        check("resume_req_addr", s_req_addr, 32'h01000010);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);

        // Request channel toggling ready.
        do_reset();
        for (int i = 0; i < 10; i++) step(0, 0, 0, (i % 2) == 0, 1);
        check("toggle_req_addr", s_req_addr, 32'h01000014);

        // Redirect with three requests outstanding.
        do_reset();
        lat_lo = 5; lat_hi = 5;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
        step(0, 1, 32'h01000100, 1, 1);
        check("redir_req_valid", {31'b0, s_req_valid}, 32'd0);
        lat_lo = 1; lat_hi = 1;
        step(0, 0, 0, 1, 1);
        check("redir_next_addr", s_req_addr, 32'h01000100);
        wait_first("redir3", 32'h01000100);

        // Redirect coinciding with a response while another is pending.
        do_reset();
        lat_lo = 2; lat_hi = 2;
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h01000200, 1, 1);
        check("redir_rsp_insn_valid", {31'b0, s_insn_valid}, 32'd0);
        wait_first("redir_rsp", 32'h01000200);

        // Fetch PC wraps at the top of the address space.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        step(0, 1, 32'hFFFFFFFC, 1, 1);
        step(0, 0, 0, 1, 1);
        check("wrap_addr0", s_req_addr, 32'hFFFFFFFC);
        step(0, 0, 0, 1, 1);
        check("wrap_addr1", s_req_addr, 32'h00000000);
        wait_first("wrap", 32'hFFFFFFFC);

        // Reset with a full buffer.
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("rst_insn_valid", {31'b0, s_insn_valid}, 32'd0);
        check("rst_req_addr", s_req_addr, 32'h01000000);
        check("rst_req_valid", {31'b0, s_req_valid}, 32'd1);

        // Random traffic.
        lat_lo = 1; lat_hi = 4;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit          r, rd;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 199) == 0);
            rd  = !r && ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0
                                              : {$urandom_range(0, 65535), 16'h0};
            step(r, rd, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
